// File: rtl/integrator_pkg.sv
// Shared types and constant helpers for the multi-channel saturating integrator.
package integrator_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  // Channel index width: at least one bit, even for a single channel.
  function automatic int ch_w(input int channels);
    return (channels <= 2) ? 1 : $clog2(channels);
  endfunction

  function automatic logic signed [63:0] sat_max(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/integrator_sat_add.sv
// Combinational signed saturating adder: result = clamp(a + b) at WIDTH bits.
module integrator_sat_add
  import integrator_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] result,
  output logic                    overflow
);

  localparam logic signed [WIDTH-1:0] MAX_V = WIDTH'(sat_max(WIDTH));
  localparam logic signed [WIDTH-1:0] MIN_V = WIDTH'(sat_min(WIDTH));

  logic signed [WIDTH:0] sum;

  always_comb begin
    sum      = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    overflow = sum[WIDTH] ^ sum[WIDTH-1];
    // Overflow only happens when both operands share a sign, so b's sign picks the rail.
    if (overflow) result = b[WIDTH-1] ? MIN_V : MAX_V;
    else          result = sum[WIDTH-1:0];
  end

endmodule

// File: rtl/integrator_sat_acc.sv
// Time-multiplexed multi-channel saturating integrator with valid/ready on both sides.
// Optional INTEGRATOR_STICKY_SAT_EN adds a per-channel sticky saturation flag port.
module integrator_sat_acc
  import integrator_pkg::*;
#(
  parameter  int WIDTH    = 10,
  parameter  int CHANNELS = 4,
  localparam int CH_W     = ch_w(CHANNELS)
) (
  input  logic                    system1000,
  input  logic                    system1000_rstn,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CH_W-1:0]         in_ch,
  input  logic signed [WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CH_W-1:0]         out_ch,
  output logic signed [WIDTH-1:0] out_data,
  output logic                    out_sat
`ifdef INTEGRATOR_STICKY_SAT_EN
  ,
  output logic [CHANNELS-1:0]     sat_sticky
`endif
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

  state_e                  state_q, state_d;
  logic [CH_W-1:0]         cnt_q, cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic [CH_W-1:0]         out_ch_q, out_ch_d;
  logic signed [WIDTH-1:0] out_data_q, out_data_d;
  logic                    out_sat_q, out_sat_d;
  logic [CHANNELS-1:0]     sticky_q, sticky_d;

  logic signed [WIDTH-1:0] acc_q [CHANNELS];
  logic                    acc_we;
  logic [CH_W-1:0]         acc_waddr;
  logic signed [WIDTH-1:0] acc_wdata;
  logic signed [WIDTH-1:0] acc_rd;

  logic                    ch_ok;
  logic                    accept;
  logic signed [WIDTH-1:0] add_result;
  logic                    add_ovf;

  assign ch_ok  = (32'(in_ch) < CHANNELS);
  assign acc_rd = ch_ok ? acc_q[in_ch] : '0;

  integrator_sat_add #(.WIDTH(WIDTH)) u_sat_add (
    .a        (acc_rd),
    .b        (in_data),
    .result   (add_result),
    .overflow (add_ovf)
  );

  // NOTE: every variable gets a default first, so no path through this block can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_ready    = 1'b0;
    acc_we      = 1'b0;
    acc_waddr   = in_ch;
    acc_wdata   = add_result;
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    sticky_d    = sticky_q;

    case (state_q)
      CLEAR: begin
        acc_we          = 1'b1;
        acc_waddr       = cnt_q;
        acc_wdata       = '0;
        sticky_d[cnt_q] = 1'b0;
        if (cnt_q == LAST_CH) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN:     in_ready = (!out_valid_q || out_ready) && !clear;
      default: state_d  = CLEAR;
    endcase

    // A clear request wins over sweep completion and restarts from channel 0.
    if (clear) begin
      state_d = CLEAR;
      cnt_d   = '0;
    end

    accept = in_valid && in_ready;
    if (accept && ch_ok) begin
      acc_we      = 1'b1;
      out_valid_d = 1'b1;
      out_ch_d    = in_ch;
      out_data_d  = add_result;
      out_sat_d   = add_ovf;
      if (add_ovf) sticky_d[in_ch] = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      state_q     <= CLEAR;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      sticky_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      sticky_q    <= sticky_d;
    end
  end

  // NOTE: the accumulator array has no reset; the CLEAR sweep zeroes it after every reset.
  always_ff @(posedge system1000) begin
    if (acc_we) acc_q[acc_waddr] <= acc_wdata;
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

`ifdef INTEGRATOR_STICKY_SAT_EN
  assign sat_sticky = sticky_q;
`else
  logic unused_sticky;
  assign unused_sticky = ^sticky_q;
`endif

endmodule

// File: tb/tb_integrator_sat_acc.sv
// Randomized and directed bench for integrator_sat_acc against a per-cycle behavioural model.
module tb_integrator_sat_acc;

  localparam int W     = 10;
  localparam int CH    = 4;
  localparam int MAX_V = (1 <<< (W - 1)) - 1;
  localparam int MIN_V = -(1 <<< (W - 1));

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic               clear, in_valid, in_ready, out_valid, out_ready, out_sat;
  logic [1:0]         in_ch, out_ch;
  logic signed [W-1:0] in_data, out_data;
  logic [CH-1:0]      sat_sticky;

  logic               in_valid3, in_ready3, out_valid3, out_sat3;
  logic [1:0]         in_ch3, out_ch3;
  logic signed [W-1:0] in_data3, out_data3;
  logic [2:0]         sat_sticky3;

  integer n_checks = 0;
  integer n_fail   = 0;

  // Behavioural model state
  int m_acc [CH];
  int clr_left;
  bit pend;
  int p_ch, p_data;
  bit p_sat;
  bit [CH-1:0] m_sticky;

  always #5 clk = ~clk;

  integrator_sat_acc #(.WIDTH(W), .CHANNELS(CH)) u_dut (
    .system1000      (clk),
    .system1000_rstn (rst_n),
    .clear           (clear),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_ch           (in_ch),
    .in_data         (in_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_ch          (out_ch),
    .out_data        (out_data),
    .out_sat         (out_sat)
`ifdef INTEGRATOR_STICKY_SAT_EN
    ,
    .sat_sticky      (sat_sticky)
`endif
  );

  integrator_sat_acc #(.WIDTH(W), .CHANNELS(3)) u_dut3 (
    .system1000      (clk),
    .system1000_rstn (rst_n),
    .clear           (1'b0),
    .in_valid        (in_valid3),
    .in_ready        (in_ready3),
    .in_ch           (in_ch3),
    .in_data         (in_data3),
    .out_valid       (out_valid3),
    .out_ready       (1'b1),
    .out_ch          (out_ch3),
    .out_data        (out_data3),
    .out_sat         (out_sat3)
`ifdef INTEGRATOR_STICKY_SAT_EN
    ,
    .sat_sticky      (sat_sticky3)
`endif
  );

`ifndef INTEGRATOR_STICKY_SAT_EN
  assign sat_sticky  = '0;
  assign sat_sticky3 = '0;
`endif

  task automatic check(input string tag, input integer got, input integer exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void sat_ref(input int a, input int b, output int r, output bit s);
    int sum;
    sum = a + b;
    s   = 1'b1;
    if (sum > MAX_V)      r = MAX_V;
    else if (sum < MIN_V) r = MIN_V;
    else begin
      r = sum;
      s = 1'b0;
    end
  endfunction

  task automatic model_init();
    clr_left = CH;
    pend     = 1'b0;
    m_sticky = '0;
    for (int i = 0; i < CH; i++) m_acc[i] = 0;
  endtask

  // Called at posedge+1: checks held outputs, drives one cycle of inputs, checks in_ready, advances.
  task automatic cycle(input bit v, input int ch, input int d, input bit ordy, input bit clr);
    bit exp_rdy;
    int r;
    bit s;
    check("out_valid", out_valid, pend);
    if (pend) begin
      check("out_ch", out_ch, p_ch);
      check("out_data", $signed(out_data), p_data);
      check("out_sat", out_sat, p_sat);
    end
`ifdef INTEGRATOR_STICKY_SAT_EN
    if (clr_left == 0) check("sat_sticky", sat_sticky, m_sticky);
`endif
    in_valid  = v;
    in_ch     = 2'(ch);
    in_data   = W'(d);
    out_ready = ordy;
    clear     = clr;
    #1;
    exp_rdy = (clr_left == 0) && (!pend || ordy) && !clr;
    check("in_ready", in_ready, exp_rdy);
    @(posedge clk);
    if (v && exp_rdy) begin
      sat_ref(m_acc[ch], d, r, s);
      m_acc[ch] = r;
      pend   = 1'b1;
      p_ch   = ch;
      p_data = r;
      p_sat  = s;
      if (s) m_sticky[ch] = 1'b1;
    end else if (pend && ordy) begin
      pend = 1'b0;
    end
    if (clr) begin
      clr_left = CH;
      m_sticky = '0;
      for (int i = 0; i < CH; i++) m_acc[i] = 0;
    end else if (clr_left > 0) begin
      clr_left--;
    end
    #1;
  endtask

  task automatic apply_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    clear    = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ch", out_ch, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_init();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_ch     = '0;
    in_data   = '0;
    out_ready = 1'b1;
    in_valid3 = 1'b0;
    in_ch3    = '0;
    in_data3  = '0;

    // Reset release: in_ready low for exactly CH cycles of sweep
    apply_reset();
    for (int i = 0; i < CH + 1; i++) cycle(0, 0, 0, 1, 0);
    check("sweep_done_ready", in_ready, 1);

    // Channel 0 accumulation through the positive rail
    cycle(1, 0, 100, 1, 0);
    cycle(1, 0, 200, 1, 0);
    cycle(1, 0, 300, 1, 0);
    check("t2_sat_value", $signed(out_data), 511);
    check("t2_sat_flag", out_sat, 1);
    cycle(1, 0, -12, 1, 0);
    check("t2_after_sat", $signed(out_data), 499);
    cycle(0, 0, 0, 1, 0);

    // Interleaved channels, negative rail
    cycle(1, 1, -300, 1, 0);
    cycle(1, 2, 7, 1, 0);
    cycle(1, 1, -300, 1, 0);
    cycle(1, 2, -7, 1, 0);
    check("t3_ch2_zero", $signed(out_data), 0);
    cycle(0, 0, 0, 1, 0);

    // Backpressure: held result stays stable, then transfers alongside a new accept
    cycle(1, 0, 5, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 3, 9, 0, 0);
    cycle(1, 0, 7, 1, 0);
    cycle(0, 0, 0, 1, 0);

    // Clear mid-stream
`ifdef INTEGRATOR_STICKY_SAT_EN
    check("t5_sticky_before", sat_sticky[0], 1);
`endif
    cycle(0, 0, 0, 1, 1);
    for (int i = 0; i < CH; i++) cycle(1, 0, 3, 1, 0);
`ifdef INTEGRATOR_STICKY_SAT_EN
    check("t5_sticky_after", sat_sticky[0], 0);
`endif
    cycle(1, 0, 5, 1, 0);
    check("t5_after_clear", $signed(out_data), 5);
    cycle(0, 0, 0, 1, 0);

    // Randomized traffic with rare clears and one mid-run reset
    for (int n = 0; n < 600; n++) begin
      int d;
      if (n == 300) begin
        apply_reset();
      end
      d = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 2 * MAX_V + 1) + MIN_V
                                       : $urandom_range(0, 60) - 30;
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, CH - 1), d,
            $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
    end
    cycle(0, 0, 0, 1, 0);

    // Three-channel instance: out-of-range channel is accepted and dropped
    in_valid3 = 1'b1;
    in_ch3    = 2'd3;
    in_data3  = W'(50);
    #1;
    check("t6_drop_ready", in_ready3, 1);
    @(posedge clk);
    #1;
    check("t6_drop_no_out", out_valid3, 0);
    in_ch3   = 2'd0;
    in_data3 = W'(1);
    @(posedge clk);
    #1;
    in_valid3 = 1'b0;
    check("t6_valid", out_valid3, 1);
    check("t6_ch", out_ch3, 0);
    check("t6_data", $signed(out_data3), 1);
    check("t6_sat", out_sat3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
